// File: rtl/smult16_err_acc.sv
// Error-statistics accumulator for a 16-bit signed approximate multiplier.
// It recomputes the exact product and accumulates error metrics over a sample window.
module smult16_err_acc #(
  parameter int WIDTH = 16,
  parameter int OUTW  = 32,
  parameter int CNTW  = 16,
  parameter int ACCW  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNTW-1:0]   num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [OUTW-1:0]   p_approx,
  output logic              busy,
  output logic              done,
  output logic [CNTW-1:0]   err_count,
  output logic [ACCW-1:0]   sum_err,
  output logic [ACCW-1:0]   sum_abs_err,
  output logic [OUTW:0]     max_abs_err,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  n_q, n_d;
  logic [CNTW-1:0]  acc_cnt_q, acc_cnt_d;

  logic             s1_valid_q, s1_valid_d;
  logic [OUTW-1:0]  s1_exact_q, s1_exact_d;
  logic [OUTW-1:0]  s1_approx_q, s1_approx_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OUTW:0]    s2_diff_q, s2_diff_d;
  logic [OUTW:0]    s2_abs_q, s2_abs_d;

  logic [CNTW-1:0]  err_count_q, err_count_d;
  logic [ACCW-1:0]  sum_err_q, sum_err_d;
  logic [ACCW-1:0]  sum_abs_q, sum_abs_d;
  logic [OUTW:0]    max_abs_q, max_abs_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             clear_results;
  logic [CNTW-1:0]  acc_cnt_inc;
  logic [OUTW-1:0]  a_ext;
  logic [OUTW-1:0]  b_ext;
  logic [OUTW-1:0]  exact_prod;
  logic [OUTW:0]    diff;
  logic [ACCW-1:0]  diff_ext;
  logic [ACCW-1:0]  sum_err_nxt;
  logic             sum_err_wrap;
  logic [ACCW:0]    sum_abs_full;

  assign in_ready      = (state_q == ST_RUN) && (acc_cnt_q < n_q);
  assign accept        = in_ready && in_valid;
  assign clear_results = (state_q == ST_IDLE) && start;
  assign acc_cnt_inc   = acc_cnt_q + CNTW'(1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    acc_cnt_d = acc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_cnt_d = '0;
          n_d       = num_samples;
          state_d   = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_inc;
          if (acc_cnt_inc == n_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      // The last sample has just reached S2 once S1 is empty, so its update lands now.
      ST_DRAIN: begin
        if (s2_valid_q && !s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Low OUTW bits of the product of sign-extended operands give the exact signed product.
  always_comb begin
    a_ext       = {{(OUTW-WIDTH){op_a[WIDTH-1]}}, op_a};
    b_ext       = {{(OUTW-WIDTH){op_b[WIDTH-1]}}, op_b};
    exact_prod  = a_ext * b_ext;
    s1_valid_d  = accept;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    if (accept) begin
      s1_exact_d  = exact_prod;
      s1_approx_d = p_approx;
    end
  end

  always_comb begin
    diff       = {s1_approx_q[OUTW-1], s1_approx_q} - {s1_exact_q[OUTW-1], s1_exact_q};
    s2_valid_d = s1_valid_q;
    s2_diff_d  = s2_diff_q;
    s2_abs_d   = s2_abs_q;
    if (s1_valid_q) begin
      s2_diff_d = diff;
      s2_abs_d  = diff[OUTW] ? (~diff + (OUTW+1)'(1)) : diff;
    end
  end

  // The absolute sum saturates; the signed sum wraps. Either event is sticky in overflow.
  always_comb begin
    diff_ext     = {{(ACCW-OUTW-1){s2_diff_q[OUTW]}}, s2_diff_q};
    sum_err_nxt  = sum_err_q + diff_ext;
    sum_err_wrap = (sum_err_q[ACCW-1] == diff_ext[ACCW-1]) &&
                   (sum_err_nxt[ACCW-1] != sum_err_q[ACCW-1]);
    sum_abs_full = {1'b0, sum_abs_q} + {{(ACCW-OUTW){1'b0}}, s2_abs_q};

    err_count_d  = err_count_q;
    sum_err_d    = sum_err_q;
    sum_abs_d    = sum_abs_q;
    max_abs_d    = max_abs_q;
    overflow_d   = overflow_q;

    if (clear_results) begin
      err_count_d = '0;
      sum_err_d   = '0;
      sum_abs_d   = '0;
      max_abs_d   = '0;
      overflow_d  = 1'b0;
    end else if (s2_valid_q) begin
      sum_err_d = sum_err_nxt;
      if (sum_err_wrap) begin
        overflow_d = 1'b1;
      end
      if (sum_abs_full[ACCW]) begin
        sum_abs_d  = '1;
        overflow_d = 1'b1;
      end else begin
        sum_abs_d = sum_abs_full[ACCW-1:0];
      end
      if (s2_abs_q > max_abs_q) begin
        max_abs_d = s2_abs_q;
      end
      if (s2_diff_q != '0) begin
        err_count_d = err_count_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_abs_q    <= '0;
      err_count_q <= '0;
      sum_err_q   <= '0;
      sum_abs_q   <= '0;
      max_abs_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      acc_cnt_q   <= acc_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_abs_q    <= s2_abs_d;
      err_count_q <= err_count_d;
      sum_err_q   <= sum_err_d;
      sum_abs_q   <= sum_abs_d;
      max_abs_q   <= max_abs_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign err_count   = err_count_q;
  assign sum_err     = sum_err_q;
  assign sum_abs_err = sum_abs_q;
  assign max_abs_err = max_abs_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_smult16_err_acc.sv
// Bench for smult16_err_acc: directed windows with literal results plus random windows,
// all checked every cycle against a cycle-timed arithmetic model of the error metrics.
module tb_smult16_err_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] p_approx;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [47:0] sum_err;
  logic [47:0] sum_abs_err;
  logic [32:0] max_abs_err;
  logic        overflow;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit chk_en       = 0;

  smult16_err_acc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .p_approx    (p_approx),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_err     (sum_err),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam longint SUM_MAX = 64'sd140737488355327;
  localparam longint SUM_MIN = -64'sd140737488355328;
  localparam longint ABS_MAX = 64'sd281474976710655;
  localparam longint WRAP    = 64'sd281474976710656;

  typedef struct {
    int     at;
    longint d;
  } pend_t;

  // Model: a window opens on an honoured start, each accepted sample's error lands two
  // edges later, and done follows the edge on which the last sample lands.
  int     cyc      = 0;
  int     done_cyc = -1;
  bit     m_open   = 0;
  bit     m_busy   = 0;
  bit     m_done   = 0;
  int     m_n      = 0;
  int     m_acc    = 0;
  int     m_cnt    = 0;
  longint m_sum    = 0;
  longint m_abs    = 0;
  longint m_max    = 0;
  bit     m_ovf    = 0;
  pend_t  pq[$];

  function automatic logic [63:0] s48(input longint v);
    logic [63:0] r;
    r = {16'h0, v[47:0]};
    return r;
  endfunction

  function automatic void clearResults();
    m_cnt = 0;
    m_sum = 0;
    m_abs = 0;
    m_max = 0;
    m_ovf = 0;
  endfunction

  function automatic void applyErr(input longint d);
    longint ad;
    ad = (d < 0) ? -d : d;
    if (d != 0) m_cnt++;
    m_sum = m_sum + d;
    if (m_sum > SUM_MAX) begin
      m_sum = m_sum - WRAP;
      m_ovf = 1;
    end else if (m_sum < SUM_MIN) begin
      m_sum = m_sum + WRAP;
      m_ovf = 1;
    end
    m_abs = m_abs + ad;
    if (m_abs > ABS_MAX) begin
      m_abs = ABS_MAX;
      m_ovf = 1;
    end
    if (ad > m_max) m_max = ad;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit     was_idle;
    longint exact;
    longint d;
    pend_t  pe;
    if (!rst_n) begin
      pq.delete();
      done_cyc = -1;
      m_open   = 0;
      m_busy   = 0;
      m_done   = 0;
      m_n      = 0;
      m_acc    = 0;
      clearResults();
    end else begin
      cyc++;
      was_idle = !m_busy && !m_done;
      m_done   = 0;
      while (pq.size() > 0 && pq[0].at == cyc) begin
        applyErr(pq[0].d);
        void'(pq.pop_front());
      end
      if (cyc == done_cyc) begin
        m_busy   = 0;
        m_done   = 1;
        done_cyc = -1;
      end
      if (was_idle && start) begin
        clearResults();
        if (num_samples == 16'd0) begin
          m_done = 1;
        end else begin
          m_busy = 1;
          m_open = 1;
          m_n    = int'(num_samples);
          m_acc  = 0;
        end
      end else if (m_open && in_valid) begin
        exact = longint'($signed(op_a)) * longint'($signed(op_b));
        d     = longint'($signed(p_approx)) - exact;
        pe.at = cyc + 2;
        pe.d  = d;
        pq.push_back(pe);
        m_acc++;
        if (m_acc == m_n) begin
          m_open   = 0;
          done_cyc = cyc + 2;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("in_ready", {63'h0, in_ready}, {63'h0, m_open});
      checkOutput("busy", {63'h0, busy}, {63'h0, m_busy});
      checkOutput("done", {63'h0, done}, {63'h0, m_done});
      checkOutput("err_count", {48'h0, err_count}, 64'(m_cnt));
      checkOutput("sum_err", {16'h0, sum_err}, s48(m_sum));
      checkOutput("sum_abs_err", {16'h0, sum_abs_err}, 64'(m_abs));
      checkOutput("max_abs_err", {31'h0, max_abs_err}, 64'(m_max));
      checkOutput("overflow", {63'h0, overflow}, {63'h0, m_ovf});
    end
  end

  task automatic startWindow(input int n, input int hold);
    start       = 1'b1;
    num_samples = n[15:0];
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    start       = 1'b0;
    num_samples = 16'($urandom);
  endtask

  task automatic applyStimulus(input int a, input int b, input longint p, input int gap);
    logic acc;
    int   tries;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    op_a     = a[15:0];
    op_b     = b[15:0];
    p_approx = p[31:0];
    in_valid = 1'b1;
    acc      = 1'b0;
    tries    = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    p_approx = $urandom;
    if (!acc) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
  endtask

  // Returns at the negedge where done is seen; lat counts negedges waited.
  task automatic waitDone(output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    if (!got) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL done_timeout: done stayed 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic checkResults(input string tag, input int cnt, input longint s,
                              input longint a, input longint mx);
    checkOutput({tag, "_err_count"}, {48'h0, err_count}, 64'(cnt));
    checkOutput({tag, "_sum_err"}, {16'h0, sum_err}, s48(s));
    checkOutput({tag, "_sum_abs"}, {16'h0, sum_abs_err}, 64'(a));
    checkOutput({tag, "_max_abs"}, {31'h0, max_abs_err}, 64'(mx));
    checkOutput({tag, "_overflow"}, {63'h0, overflow}, 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic genTriple(output int a, output int b, output longint p);
    longint exact;
    int     mode;
    a = $urandom_range(0, 65535) - 32768;
    b = $urandom_range(0, 65535) - 32768;
    if ($urandom_range(0, 7) == 0) a = -32768;
    if ($urandom_range(0, 7) == 0) b = -32768;
    exact = longint'(a) * longint'(b);
    mode  = $urandom_range(0, 3);
    case (mode)
      0:       p = exact;
      1:       p = exact + longint'($urandom_range(0, 16)) - 8;
      2:       p = longint'(int'($urandom));
      default: p = exact ^ (64'sd1 << $urandom_range(0, 31));
    endcase
  endtask

  int     lat;
  int     ra;
  int     rb;
  longint rp;
  int     rn;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = 16'd0;
    in_valid    = 1'b0;
    op_a        = 16'd0;
    op_b        = 16'd0;
    p_approx    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_done", {63'h0, done}, 64'h0);
    checkOutput("rst_overflow", {63'h0, overflow}, 64'h0);
    checkOutput("rst_err_count", {48'h0, err_count}, 64'h0);
    checkOutput("rst_sum_err", {16'h0, sum_err}, 64'h0);
    checkOutput("rst_sum_abs", {16'h0, sum_abs_err}, 64'h0);
    checkOutput("rst_max_abs", {31'h0, max_abs_err}, 64'h0);
    rst_n  = 1'b1;
    chk_en = 1;
    @(posedge clk);
    #1;

    // Exact multiplier: no error at all, done two edges after the last accept.
    startWindow(4, 1);
    applyStimulus(3, -5, -15, 0);
    applyStimulus(-32768, -32768, 1073741824, 0);
    applyStimulus(0, 7, 0, 0);
    applyStimulus(100, 100, 10000, 0);
    waitDone(lat);
    checkOutput("t1_done_latency", 64'(lat), 64'd3);
    checkResults("t1", 0, 0, 0, 0);

    startWindow(3, 1);
    applyStimulus(10, 10, 96, 0);
    applyStimulus(-4, 6, -20, 1);
    applyStimulus(2, 2, 4, 0);
    waitDone(lat);
    checkResults("t2", 2, 0, 8, 4);

    // Largest possible error magnitude: -2^31 returned for +2^30.
    startWindow(2, 1);
    applyStimulus(-32768, -32768, -64'sd2147483648, 0);
    applyStimulus(1, 1, 1, 0);
    waitDone(lat);
    checkResults("t3", 1, -64'sd3221225472, 64'sd3221225472, 64'sd3221225472);

    // Bubbles between samples; in_ready must drop right on the fifth accept.
    startWindow(5, 1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(i, i, longint'(i * i + 1), (i == 1) ? 0 : 2);
    end
    checkOutput("t4_ready_drop", {63'h0, in_ready}, 64'h0);
    waitDone(lat);
    checkOutput("t4_done_latency", 64'(lat), 64'd3);
    checkResults("t4", 5, 5, 5, 1);

    startWindow(0, 1);
    waitDone(lat);
    checkOutput("t5_done_latency", 64'(lat), 64'd1);
    checkResults("t5", 0, 0, 0, 0);

    // A start pulse during RUN must not restart or shorten the window.
    startWindow(3, 1);
    applyStimulus(7, -3, -21, 0);
    startWindow(1, 1);
    applyStimulus(-2, -2, 5, 0);
    applyStimulus(300, -300, -90000, 0);
    waitDone(lat);
    checkOutput("t6_done_latency", 64'(lat), 64'd3);
    checkResults("t6", 1, 1, 1, 1);

    // Reset mid-window clears everything at once.
    startWindow(4, 1);
    applyStimulus(1, 1, 2, 0);
    applyStimulus(2, 2, 5, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_busy", {63'h0, busy}, 64'h0);
    checkOutput("t7_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("t7_err_count", {48'h0, err_count}, 64'h0);
    checkOutput("t7_sum_abs", {16'h0, sum_abs_err}, 64'h0);
    checkOutput("t7_max_abs", {31'h0, max_abs_err}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t7_idle_busy", {63'h0, busy}, 64'h0);
    checkOutput("t7_idle_done", {63'h0, done}, 64'h0);
    startWindow(1, 1);
    applyStimulus(5, 5, 24, 0);
    waitDone(lat);
    checkResults("t7b", 1, -1, 1, 1);

    // Random windows; start sometimes held over several cycles.
    for (int w = 0; w < 14; w++) begin
      rn = $urandom_range(1, 30);
      startWindow(rn, $urandom_range(1, 3));
      for (int i = 0; i < rn; i++) begin
        genTriple(ra, rb, rp);
        applyStimulus(ra, rb, rp, $urandom_range(0, 2));
      end
      waitDone(lat);
      checkOutput("rand_done_latency", 64'(lat), 64'd3);
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/smult16_err_acc.md
# smult16_err_acc

Error-statistics accumulator placed directly downstream of the 16-bit signed approximate multiplier. It consumes each operand pair together with the product returned by the multiplier and recomputes the exact product internally. Over a programmable window of samples it accumulates the error sum, the absolute-error sum, the maximum absolute error and the count of erroneous products. These are the error metrics used to qualify each approximate multiplier variant in hardware rather than by offline post-processing.

## Interface
Parameters:
- WIDTH, 16, operand width (signed)
- OUTW, 32, product width (signed); equals 2*WIDTH
- CNTW, 16, sample-counter width
- ACCW, 48, width of the accumulators

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock only
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that opens a window; honoured only in IDLE
- num_samples  in  CNTW  window length; sampled on the start cycle
- in_valid  in  1  an operand/product triple is present
- in_ready  out  1  block accepts a triple this cycle
- op_a, op_b  in  WIDTH  signed operands fed to the multiplier
- p_approx  in  OUTW  signed product returned by the multiplier
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results are final
- err_count  out  CNTW  number of samples with p_approx ≠ exact
- sum_err  out  ACCW  signed sum of (p_approx − exact)
- sum_abs_err  out  ACCW  unsigned sum of |p_approx − exact|, saturating
- max_abs_err  out  OUTW+1  largest |p_approx − exact| in the window
- overflow  out  1  sticky; set when sum_abs_err saturates or sum_err wraps

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
- IDLE → RUN: start=1 and num_samples≠0.
  - On that edge, every result output, overflow and the accept counter clear to 0.
  - num_samples is latched.
- IDLE → DONE: start=1 and num_samples=0. Results clear and done pulses with all-zero results.
- start is ignored outside IDLE.
- RUN:
  - in_ready=1 while the accept count < latched num_samples.
  - A triple is accepted on an edge where in_valid && in_ready.
  - On the accepting edge that reaches num_samples, the FSM moves to DRAIN and in_ready drops.
- Pipeline per accepted triple:
  - S1 registers exact = op_a*op_b (signed, full OUTW) and p_approx.
  - S2 registers d = p_approx − exact (signed, OUTW+1 bits, no overflow possible) and |d| (OUTW+1 bits unsigned).
  - The accumulate stage then performs all of the following:
    - sum_err += sign-extend(d); on wrap it wraps and sets overflow.
    - sum_abs_err += |d|; on overflow it saturates to all-ones and sets overflow.
    - max_abs_err = max(max_abs_err, |d|).
    - err_count += (d≠0).
- DRAIN → DONE: when the last accepted sample's accumulate update occurs.
- DONE → IDLE: after one cycle. done=1 only while in DONE.
- Results hold their values after DONE until the next honoured start.
- Bubbles (in_valid=0) inside RUN insert no update and do not stall the pipeline.

## Timing
- Reset values: in_ready=0, busy=0, done=0, overflow=0, and all results 0. The FSM resets to IDLE and pipeline valid bits clear.
- The start edge is k. RUN begins at k+1, and in_ready can be high in the cycle after k.
- Sample latency: accepted at edge m → S1 at m → S2 at m+1 → accumulators updated at m+2.
- Final sample accepted at edge m:
  - The FSM enters DONE at edge m+2.
  - done is high for the cycle after m+2.
  - Final result values are visible in that same cycle.
- Maximum throughput is one sample per cycle; in_ready never depends combinationally on in_valid.
- If rst_n is asserted mid-window, all state clears immediately and asynchronously. No done is produced, and the next window needs a new start.
- A start held high over several cycles opens only one window; DONE→IDLE at least one cycle later is required before the next start is honoured.

## Test plan
- Exact multiplier, num_samples=4, triples (3,−5,−15), (−32768,−32768,1073741824), (0,7,0), (100,100,10000) → done=1 at accept+2; err_count=0, sum_err=0, sum_abs_err=0, max=0.
- num_samples=3: (10,10,96), (−4,6,−20), (2,2,4) → err_count=2, sum_err=0, sum_abs_err=8, max_abs_err=4.
- num_samples=2: (−32768,−32768,−2147483648), (1,1,1) → d=−3221225472; sum_abs_err=3221225472, max=3221225472, overflow=0.
- num_samples=5 with in_valid toggling 1,0,0,1,… → exactly 5 accepts; in_ready drops on the 5th accept edge; done 2 edges later.
- start with num_samples=0 → done at k+1 with all results 0. In a second test, start pulsed during RUN is ignored.
- Reset: rst_n low after 2 of 4 samples → all outputs 0 at once, FSM in IDLE. A fresh window with 1 sample (5,5,24) → err_count=1, sum_abs_err=1.
